// File: rtl/simon_pkg.sv
// Constants and helpers shared by the SIMON key-schedule slice:
// z-sequences, per-family round/z-index lookup, rotates and FSM encodings.
package simon_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bit 61 of each entry is z_j[0]; the sequence is read MSB-first.
    localparam logic [61:0] SIMON_Z [5] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    function automatic int unsigned simon_rounds(input int unsigned n, input int unsigned m);
        int unsigned r;
        r = 0;
        case (n)
            16: if (m == 4) r = 32;
            24: if (m == 3 || m == 4) r = 36;
            32: if (m == 3) r = 42; else if (m == 4) r = 44;
            48: if (m == 2) r = 52; else if (m == 3) r = 54;
            64: if (m == 2) r = 68; else if (m == 3) r = 69; else if (m == 4) r = 72;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic int unsigned simon_zidx(input int unsigned n, input int unsigned m);
        int unsigned j;
        j = 0;
        case (n)
            24: if (m == 4) j = 1;
            32: if (m == 3) j = 2; else if (m == 4) j = 3;
            48: if (m == 2) j = 2; else if (m == 3) j = 3;
            64: if (m == 2) j = 2; else if (m == 3) j = 3; else if (m == 4) j = 4;
            default: j = 0;
        endcase
        return j;
    endfunction

    function automatic logic [61:0] simon_zseq(input int unsigned j);
        logic [61:0] z;
        case (j)
            0: z = SIMON_Z[0];
            1: z = SIMON_Z[1];
            2: z = SIMON_Z[2];
            3: z = SIMON_Z[3];
            default: z = SIMON_Z[4];
        endcase
        return z;
    endfunction

    // Rotates act on the low w bits of a 64-bit carrier; upper bits are cleared.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned s, input int unsigned w);
        logic [63:0] msk;
        logic [63:0] xm;
        msk = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm  = x & msk;
        return ((xm >> s) | (xm << (w - s))) & msk;
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned s, input int unsigned w);
        return rotr(x, w - s, w);
    endfunction

endpackage

// File: rtl/simon_rk_buffer.sv
// T x N round-key store: one write port, one registered read port that
// returns zero for addresses beyond the last round key.
module simon_rk_buffer
    import simon_pkg::*;
#(
    parameter int N = 16,
    parameter int T = 32,
    parameter int C = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [C-1:0] wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [C-1:0] rd_addr,
    output logic [N-1:0] rd_data
);

    localparam int AW = (T > 1) ? $clog2(T) : 1;
    localparam logic [C:0] DEPTH = (C+1)'(T);

    logic [N-1:0] mem [T];
    logic         wr_ok;
    logic         rd_ok;

    assign wr_ok = ({1'b0, wr_addr} < DEPTH);
    assign rd_ok = ({1'b0, rd_addr} < DEPTH);

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_ok ? mem[rd_addr[AW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/simon_keyschedule_buf.sv
// SIMON N/M key schedule: expands the master key into T round keys held in a
// buffer that the round core reads in encryption or decryption order.
module simon_keyschedule_buf
    import simon_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32,
    parameter int J = 0,
    parameter int C = 6
) (
    input  logic                clk,
    input  logic                nR,
    input  logic                newKey,
    input  logic [M-1:0][N-1:0] key,
    input  logic [C-1:0]        rdRound,
    output logic [N-1:0]        rKey,
    output logic [C-1:0]        count,
    output logic                busyKey,
    output logic                doneKey
);

    if (simon_rounds(N, M) == 0 || T < 1 || T > (1 << C) || J < 0 || J > 4) begin : g_bad_cfg
        $error("simon_keyschedule_buf: unsupported N/M/T/C combination");
    end

    localparam logic [C-1:0] LAST = C'(T - 1);

    logic [1:0]          state;
    logic                new_key_q;
    logic                start;
    logic [M-1:0][N-1:0] kr;
    logic [5:0]          zp;
    logic [61:0]         zseq;
    logic                zbit;
    logic [N-1:0]        tmp;
    logic [N-1:0]        f;
    logic                wr_en;

    assign start = newKey & ~new_key_q;
    assign zseq  = simon_zseq(J);
    assign zbit  = zseq[6'd61 - zp];
    // The load edge itself never writes; the first write is k0 on the next edge.
    assign wr_en = (state == BUSY) & ~start;

    always_comb begin
        tmp = N'(rotr(64'(kr[M-1]), 3, N));
        if (M == 4) begin
            tmp = tmp ^ kr[1];
        end
        tmp = tmp ^ N'(rotr(64'(tmp), 1, N));
        f   = ~kr[0] ^ tmp ^ {{(N-2){1'b0}}, 1'b1, ~zbit};
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state     <= IDLE;
            new_key_q <= 1'b0;
            kr        <= '0;
            zp        <= '0;
            count     <= '0;
            busyKey   <= 1'b0;
            doneKey   <= 1'b0;
        end else begin
            new_key_q <= newKey;
            if (start) begin
                state   <= BUSY;
                kr      <= key;
                zp      <= '0;
                count   <= '0;
                busyKey <= 1'b1;
                doneKey <= 1'b0;
            end else if (state == BUSY) begin
                kr    <= {f, kr[M-1:1]};
                zp    <= (zp == 6'd61) ? 6'd0 : zp + 6'd1;
                count <= count + C'(1);
                if (count == LAST) begin
                    state   <= DONE;
                    busyKey <= 1'b0;
                    doneKey <= 1'b1;
                end
            end
        end
    end

    simon_rk_buffer #(
        .N(N),
        .T(T),
        .C(C)
    ) u_rk_buffer (
        .clk    (clk),
        .rst_n  (nR),
        .wr_en  (wr_en),
        .wr_addr(count),
        .wr_data(kr[0]),
        .rd_addr(rdRound),
        .rd_data(rKey)
    );

endmodule

// File: tb/tb_simon_keyschedule_buf.sv
// Scoreboard bench for simon_keyschedule_buf: SIMON32/64 and SIMON128/256
// instances, read results checked by a monitor against queued expectations.
module tb_simon_keyschedule_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             nR;
    logic             new_key16, new_key64;
    logic [3:0][15:0] key16;
    logic [3:0][63:0] key64;
    logic [5:0]       rd_round16;
    logic [6:0]       rd_round64;
    logic [15:0]      rkey16;
    logic [63:0]      rkey64;
    logic [5:0]       cnt16;
    logic [6:0]       cnt64;
    logic             busy16, done16, busy64, done64;

    simon_keyschedule_buf #(.N(16), .M(4), .T(32), .J(0), .C(6)) dut16 (
        .clk(clk), .nR(nR), .newKey(new_key16), .key(key16), .rdRound(rd_round16),
        .rKey(rkey16), .count(cnt16), .busyKey(busy16), .doneKey(done16)
    );

    simon_keyschedule_buf #(.N(64), .M(4), .T(72), .J(4), .C(7)) dut64 (
        .clk(clk), .nR(nR), .newKey(new_key64), .key(key64), .rdRound(rd_round64),
        .rKey(rkey64), .count(cnt64), .busyKey(busy64), .doneKey(done64)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t        q16[$];
    exp_t        q64[$];
    logic        req16 = 1'b0, req64 = 1'b0;
    logic        req16_q = 1'b0, req64_q = 1'b0;
    logic [63:0] gold [72];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
        logic [63:0] msk;
        msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        return (((x & msk) >> r) | ((x & msk) << (n - r))) & msk;
    endfunction

    function automatic bit zbit(input int j, input int i);
        string s;
        case (j)
            0: s = "11111010001001010110000111001101111101000100101011000011100110";
            4: s = "11010001111001101011011000100000010111000011001010010011101111";
            default: s = "00000000000000000000000000000000000000000000000000000000000000";
        endcase
        return s[i] == "1";
    endfunction

    // Reference schedule written in array form: k[i] from k[i-1], k[i-3], k[i-m].
    task automatic build_gold(input int n, input int m, input int t, input int j,
                              input logic [63:0] k0, input logic [63:0] k1,
                              input logic [63:0] k2, input logic [63:0] k3);
        logic [63:0] msk, tmp;
        msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        gold[0] = k0; gold[1] = k1; gold[2] = k2; gold[3] = k3;
        for (int i = m; i < t; i++) begin
            tmp = ror(gold[i-1], 3, n);
            if (m == 4) tmp = tmp ^ gold[i-3];
            tmp = tmp ^ ror(tmp, 1, n);
            gold[i] = (~gold[i-m] ^ tmp ^ 64'd3 ^ {63'd0, zbit(j, (i - m) % 62)}) & msk;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd16(input int a, input logic [15:0] e, input string nm);
        exp_t x;
        rd_round16 = 6'(a);
        req16      = 1'b1;
        x.name = nm;
        x.val  = {48'd0, e};
        q16.push_back(x);
        tick();
        req16 = 1'b0;
    endtask

    task automatic rd64(input int a, input logic [63:0] e, input string nm);
        exp_t x;
        rd_round64 = 7'(a);
        req64      = 1'b1;
        x.name = nm;
        x.val  = e;
        q64.push_back(x);
        tick();
        req64 = 1'b0;
    endtask

    task automatic start16(input string nm);
        new_key16 = 1'b1;
        tick();
        chk({nm, "_busy"},  64'(busy16), 64'd1);
        chk({nm, "_done"},  64'(done16), 64'd0);
        chk({nm, "_count"}, 64'(cnt16),  64'd0);
    endtask

    // Called just after a start edge; newKey is dropped after 'hold' further edges.
    task automatic wait_done16(input string nm, input int hold);
        int cyc;
        cyc = 0;
        while (done16 !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == hold) new_key16 = 1'b0;
        end
        new_key16 = 1'b0;
        chk(nm, 64'(cyc), 64'd32);
    endtask

    always @(posedge clk) begin
        req16_q <= req16;
        req64_q <= req64;
    end

    always @(negedge clk) begin
        exp_t x;
        if (req16_q) begin
            if (q16.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb16_pop: got read with empty queue expected queued entry");
            end else begin
                x = q16.pop_front();
                chk(x.name, {48'd0, rkey16}, x.val);
            end
        end
        if (req64_q) begin
            if (q64.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb64_pop: got read with empty queue expected queued entry");
            end else begin
                x = q64.pop_front();
                chk(x.name, rkey64, x.val);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        nR = 1'b0; new_key16 = 1'b0; new_key64 = 1'b0;
        key16 = '0; key64 = '0; rd_round16 = '0; rd_round64 = '0;
        repeat (3) tick();
        chk("rst_rkey",  64'(rkey16), 64'd0);
        chk("rst_count", 64'(cnt16),  64'd0);
        chk("rst_busy",  64'(busy16), 64'd0);
        chk("rst_done",  64'(done16), 64'd0);
        chk("rst_done64", 64'(done64), 64'd0);
        nR = 1'b1;
        repeat (2) tick();

        // SIMON32/64 reference key, single-cycle pulse
        key16 = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
        build_gold(16, 4, 32, 0, 64'h0100, 64'h0908, 64'h1110, 64'h1918);
        start16("start_a");
        new_key16 = 1'b0;
        wait_done16("done_lat_a", 0);
        chk("done_a_busy", 64'(busy16), 64'd0);
        rd16(0, 16'h0100, "hand_rk0");
        rd16(1, 16'h0908, "hand_rk1");
        rd16(2, 16'h1110, "hand_rk2");
        rd16(3, 16'h1918, "hand_rk3");
        rd16(4, 16'h71c3, "hand_rk4");
        rd16(5, 16'hb649, "hand_rk5");
        for (int i = 0; i < 32; i++) rd16(i, gold[i][15:0], $sformatf("rk_a[%0d]", i));

        // newKey held high for 22 clocks: one expansion only
        key16 = {16'h0f0e, 16'h0d0c, 16'h0b0a, 16'h0908};
        build_gold(16, 4, 32, 0, 64'h0908, 64'h0b0a, 64'h0d0c, 64'h0f0e);
        start16("start_b");
        wait_done16("done_lat_b", 21);
        repeat (10) tick();
        chk("held_done", 64'(done16), 64'd1);
        chk("held_busy", 64'(busy16), 64'd0);
        rd16(0,  gold[0][15:0],  "rk_b[0]");
        rd16(4,  gold[4][15:0],  "rk_b[4]");
        rd16(31, gold[31][15:0], "rk_b[31]");

        // restart at count=10 with an all-zero key
        key16 = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
        start16("start_c");
        new_key16 = 1'b0;
        cyc = 0;
        while (cnt16 !== 6'd10 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("reach_count10", 64'(cyc), 64'd10);
        key16 = '0;
        start16("restart_c");
        new_key16 = 1'b0;
        wait_done16("done_lat_restart", 0);
        build_gold(16, 4, 32, 0, 64'd0, 64'd0, 64'd0, 64'd0);
        for (int i = 0; i < 4; i++) rd16(i, 16'h0000, $sformatf("zero_rk%0d", i));
        for (int i = 31; i >= 0; i--) rd16(i, gold[i][15:0], $sformatf("dec_zero[%0d]", i));
        rd16(40, 16'h0000, "oob_40");
        rd16(32, 16'h0000, "oob_32");

        // SIMON128/256: 72 keys, z pointer wraps 61 -> 0
        key64 = {64'h1f1e1d1c1b1a1918, 64'h1716151413121110,
                 64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
        build_gold(64, 4, 72, 4, 64'h0706050403020100, 64'h0f0e0d0c0b0a0908,
                   64'h1716151413121110, 64'h1f1e1d1c1b1a1918);
        new_key64 = 1'b1;
        tick();
        new_key64 = 1'b0;
        chk("start64_busy", 64'(busy64), 64'd1);
        cyc = 0;
        while (done64 !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("done_lat_64", 64'(cyc), 64'd72);
        for (int i = 0; i < 72; i++) rd64(i, gold[i], $sformatf("rk64[%0d]", i));
        rd64(100, 64'd0, "oob64_100");

        // asynchronous reset while an expansion is in flight
        key16 = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
        start16("start_d");
        new_key16  = 1'b0;
        rd_round16 = 6'd0;
        repeat (6) tick();
        chk("pre_rst_rkey", 64'(rkey16), 64'h0100);
        #2;
        nR = 1'b0;
        #1;
        chk("arst_rkey",  64'(rkey16), 64'd0);
        chk("arst_count", 64'(cnt16),  64'd0);
        chk("arst_busy",  64'(busy16), 64'd0);
        chk("arst_done",  64'(done16), 64'd0);
        chk("arst_done64", 64'(done64), 64'd0);
        tick();
        nR = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", 64'(busy16), 64'd0);

        chk("sb16_empty", 64'(q16.size()), 64'd0);
        chk("sb64_empty", 64'(q64.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
